lane_resize_buffer: RTL and testbench
=====================================

Name: lane_resize_buffer

Overview:
- Parametrised lane-repacking buffer for the stream resizer datapath, between the slave-side unpacker and the master-side packer.
- Accepts S_KEEP_WIDTH lanes per slave beat and stores only kept lanes in a circular lane store of DEPTH entries.
- Emits M_KEEP_WIDTH lanes per master beat, flushing a partial beat at each last lane.
- Both sides use a full valid/ready handshake. Overflow and underflow are reported as registered diagnostic pulses.

Parameters:
- S_KEEP_WIDTH, 3: lanes per slave beat (>=1).
- M_KEEP_WIDTH, 2: lanes per master beat (>=1).
- T_DATA_WIDTH, 1: data bits per lane (>=1).
- DEPTH, 8: lane store capacity in lanes. Must be >= S_KEEP_WIDTH + M_KEEP_WIDTH.
- LANE_SZ, 2+T_DATA_WIDTH: derived lane width. Bit [T_DATA_WIDTH+1] is keep, bit [T_DATA_WIDTH] is last, bits [T_DATA_WIDTH-1:0] are data.
- BUF_IN_ENTRY_SZ, LANE_SZ*S_KEEP_WIDTH: derived.
- BUF_OUT_ENTRY_SZ, LANE_SZ*M_KEEP_WIDTH: derived.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- slave_entry_valid  in  1  slave beat present.
- slave_entry_ready  out  1  buffer can accept a full slave beat.
- slave_entry  in  BUF_IN_ENTRY_SZ  slave lanes; lane i occupies bits [(i+1)*LANE_SZ-1 : i*LANE_SZ], and lane 0 is first in stream order.
- master_entry_valid  out  1  master beat present.
- master_entry_ready  in  1  sink accepts the master beat.
- master_entry  out  BUF_OUT_ENTRY_SZ  master lanes, same packing as slave_entry.
- level  out  $clog2(DEPTH+1)  lanes currently stored.
- overflow  out  1  registered pulse: the slave side was stalled.
- underflow  out  1  registered pulse: the master side was starved.

Behaviour:
- Reset: rst=1 clears the read pointer, write pointer, level, overflow and underflow immediately, without waiting for clk.
  - master_entry_valid=0 and master_entry=0 during reset.
  - slave_entry_ready=1 after release.
  - Stored lanes are discarded, including on reset mid-transfer.
- Ready: slave_entry_ready = (DEPTH - level) >= S_KEEP_WIDTH.
  - Computed from the current level only.
  - A same-cycle pop gives no credit.
- Write, on slave_entry_valid & slave_entry_ready:
  - Lanes with keep=0 are discarded, including their last bit.
  - Kept lanes are written in lane order to consecutive store slots from the write pointer, modulo DEPTH.
  - The write pointer advances by the kept count k (0..S_KEEP_WIDTH).
- Flush point: f = index (0-based) of the first stored lane with last=1 among the oldest min(level, M_KEEP_WIDTH) lanes, if one exists.
- Valid: master_entry_valid = (level >= M_KEEP_WIDTH) OR (flush point exists).
  - It is a combinational function of registered state.
  - Input-to-output latency is 1 cycle: lanes written at edge N are visible after edge N.
- Output lane count: n = f+1 if a flush point exists, else M_KEEP_WIDTH.
  - master_entry lanes 0..n-1 are the oldest stored lanes, with keep=1 and their stored last/data.
  - Lanes n..M_KEEP_WIDTH-1 are all-zero.
  - master_entry is all-zero whenever master_entry_valid=0.
- Read, on master_entry_valid & master_entry_ready: the read pointer advances by n, modulo DEPTH.
- Simultaneous write and read in one cycle: level_next = level + k - n. Both pointers wrap independently.
- Stall behaviour: a stalled slave beat is not consumed. The buffer never drops accepted lanes.
- Flags:
  - overflow is set at the edge following any cycle with slave_entry_valid=1 and slave_entry_ready=0. It is cleared at the next edge if the condition is absent.
  - underflow behaves the same way for master_entry_ready=1 with master_entry_valid=0.
- Width: level never exceeds DEPTH. Pointer arithmetic wraps modulo DEPTH, which need not be a power of two.

Test Plan (S=3, T=1, M=2, DEPTH=8 unless noted):
1. Reset: hold rst=1 for 3 cycles, then release.
   -> All outputs 0 during reset. After release, slave_entry_ready=1, level=0, master_entry_valid=0.
2. Single beat 9'b101100111 with master_entry_ready=1.
   -> level=3. Next cycle master_entry=6'b000111 (flush at lane 0), valid=1.
   -> Then 6'b101100, level 2->0, valid=0.
3. Compaction: beat 9'b100000101 (lane 1 unkept).
   -> level=2. master_entry=6'b100101 valid. After pop, level=0.
4. Fill: master_entry_ready=0, hold 9'b100100100 valid.
   -> Two beats accepted, level=6, slave_entry_ready=0. overflow=1 from the next edge while valid is held.
   -> Raise master_entry_ready: beats of 6'b100100 drain, a third beat is accepted when level<=5, and overflow returns to 0.
5. Starve: buffer empty, master_entry_ready=1 for 4 cycles.
   -> underflow=1 from the edge after the first cycle until one edge after ready drops. master_entry stays 0.
6. Async reset mid-operation: at level=6, pulse rst between clock edges.
   -> level=0, master_entry_valid=0 and master_entry=0 immediately. Wrap-around writes then work from pointer 0.

Source files
------------

// File: rtl/lane_resize_buffer_if.sv
// Handshake and status bundle for lane_resize_buffer.
// The master modport is the buffer's own view; the slave modport is the environment's view.
interface lane_resize_buffer_if #(
  parameter int S_KEEP_WIDTH = 3,
  parameter int M_KEEP_WIDTH = 2,
  parameter int T_DATA_WIDTH = 1,
  parameter int DEPTH        = 8
);
  localparam int LANE_SZ          = 2 + T_DATA_WIDTH;
  localparam int BUF_IN_ENTRY_SZ  = LANE_SZ * S_KEEP_WIDTH;
  localparam int BUF_OUT_ENTRY_SZ = LANE_SZ * M_KEEP_WIDTH;
  localparam int LVL_W            = $clog2(DEPTH + 1);

  logic                        slave_entry_valid;
  logic                        slave_entry_ready;
  logic [BUF_IN_ENTRY_SZ-1:0]  slave_entry;
  logic                        master_entry_valid;
  logic                        master_entry_ready;
  logic [BUF_OUT_ENTRY_SZ-1:0] master_entry;
  logic [LVL_W-1:0]            level;
  logic                        overflow;
  logic                        underflow;

  modport master (
    input  slave_entry_valid, slave_entry, master_entry_ready,
    output slave_entry_ready, master_entry_valid, master_entry, level, overflow, underflow
  );

  modport slave (
    output slave_entry_valid, slave_entry, master_entry_ready,
    input  slave_entry_ready, master_entry_valid, master_entry, level, overflow, underflow
  );
endinterface

// File: rtl/lane_resize_buffer.sv
// Lane-repacking buffer: compacts kept slave lanes into a circular lane store and
// emits master beats of M_KEEP_WIDTH lanes, cutting a beat short at each last lane.
module lane_resize_buffer #(
  parameter int S_KEEP_WIDTH = 3,
  parameter int M_KEEP_WIDTH = 2,
  parameter int T_DATA_WIDTH = 1,
  parameter int DEPTH        = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  lane_resize_buffer_if.master  bus
);
  localparam int LANE_SZ          = 2 + T_DATA_WIDTH;
  localparam int STORE_W          = T_DATA_WIDTH + 1;
  localparam int BUF_OUT_ENTRY_SZ = LANE_SZ * M_KEEP_WIDTH;
  localparam int PTR_W            = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W            = $clog2(DEPTH + 1);
  localparam int SUM_W            = PTR_W + 2;

  // Pointer advance modulo DEPTH; inc never exceeds DEPTH so one subtraction suffices.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] ptr,
                                                input logic [LVL_W-1:0] inc);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(ptr) + SUM_W'(inc);
    if (sum >= SUM_W'(DEPTH)) begin
      sum = sum - SUM_W'(DEPTH);
    end else begin
      sum = sum;
    end
    return sum[PTR_W-1:0];
  endfunction

  // Keep bit is implied for stored lanes, so only last+data are held.
  logic [STORE_W-1:0]          r_store [DEPTH];
  logic [PTR_W-1:0]            r_rd_ptr;
  logic [PTR_W-1:0]            r_wr_ptr;
  logic [LVL_W-1:0]            r_level;
  logic                        r_overflow;
  logic                        r_underflow;

  logic [S_KEEP_WIDTH-1:0]     w_keep;
  logic [PTR_W-1:0]            w_wr_slot [S_KEEP_WIDTH];
  logic [LVL_W-1:0]            w_kcnt;
  logic [LVL_W-1:0]            w_ncnt;
  logic                        w_hit;
  logic                        w_flush;
  logic                        w_m_valid;
  logic                        w_s_ready;
  logic                        w_push;
  logic                        w_pop;
  logic [BUF_OUT_ENTRY_SZ-1:0] w_m_entry;

  // Compaction: each kept lane gets the next free slot after the kept lanes before it.
  always_comb begin
    w_kcnt = '0;
    w_keep = '0;
    for (int i = 0; i < S_KEEP_WIDTH; i++) begin
      w_keep[i]    = bus.slave_entry[i*LANE_SZ + LANE_SZ - 1];
      w_wr_slot[i] = wrap_add(r_wr_ptr, w_kcnt);
      w_kcnt       = w_kcnt + LVL_W'(w_keep[i]);
    end
  end

  // Flush search over the oldest lanes, then assemble the outgoing beat.
  always_comb begin
    w_hit     = 1'b0;
    w_flush   = 1'b0;
    w_ncnt    = LVL_W'(M_KEEP_WIDTH);
    w_m_entry = '0;
    for (int j = 0; j < M_KEEP_WIDTH; j++) begin
      w_hit   = !w_flush && (LVL_W'(j) < r_level)
                && r_store[wrap_add(r_rd_ptr, LVL_W'(j))][T_DATA_WIDTH];
      w_ncnt  = w_hit ? LVL_W'(j + 1) : w_ncnt;
      w_flush = w_flush | w_hit;
    end
    w_m_valid = (r_level >= LVL_W'(M_KEEP_WIDTH)) || w_flush;
    for (int j = 0; j < M_KEEP_WIDTH; j++) begin
      if (w_m_valid && (LVL_W'(j) < w_ncnt)) begin
        w_m_entry[j*LANE_SZ +: LANE_SZ] = {1'b1, r_store[wrap_add(r_rd_ptr, LVL_W'(j))]};
      end else begin
        w_m_entry[j*LANE_SZ +: LANE_SZ] = '0;
      end
    end
  end

  // Ready is withheld while reset is asserted so nothing is accepted into a clearing buffer.
  assign w_s_ready = !rst && ((LVL_W'(DEPTH) - r_level) >= LVL_W'(S_KEEP_WIDTH));
  assign w_push    = bus.slave_entry_valid & w_s_ready;
  assign w_pop     = w_m_valid & bus.master_entry_ready;

  // Pointer, occupancy and diagnostic flag state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_ptr    <= w_push ? wrap_add(r_wr_ptr, w_kcnt) : r_wr_ptr;
      r_rd_ptr    <= w_pop ? wrap_add(r_rd_ptr, w_ncnt) : r_rd_ptr;
      r_level     <= r_level + (w_push ? w_kcnt : LVL_W'(0)) - (w_pop ? w_ncnt : LVL_W'(0));
      r_overflow  <= bus.slave_entry_valid & !w_s_ready;
      r_underflow <= bus.master_entry_ready & !w_m_valid;
    end
  end

  // Lane store writes; contents beyond the valid window are never observed, so no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < S_KEEP_WIDTH; i++) begin
      if (w_push && w_keep[i]) begin
        r_store[w_wr_slot[i]] <= bus.slave_entry[i*LANE_SZ +: STORE_W];
      end
    end
  end

  assign bus.slave_entry_ready  = w_s_ready;
  assign bus.master_entry_valid = w_m_valid;
  assign bus.master_entry       = w_m_entry;
  assign bus.level              = r_level;
  assign bus.overflow           = r_overflow;
  assign bus.underflow          = r_underflow;
endmodule

// File: tb/tb_lane_resize_buffer.sv
// Directed self-checking bench for lane_resize_buffer (S=3, M=2, T=1, DEPTH=8).
module tb_lane_resize_buffer;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  lane_resize_buffer_if #(.S_KEEP_WIDTH(3), .M_KEEP_WIDTH(2), .T_DATA_WIDTH(1), .DEPTH(8)) bus ();

  lane_resize_buffer #(.S_KEEP_WIDTH(3), .M_KEEP_WIDTH(2), .T_DATA_WIDTH(1), .DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.slave_entry_valid  = 1'b0;
    bus.slave_entry        = 9'b000000000;
    bus.master_entry_ready = 1'b0;
    repeat (3) tick();
    n_checks++; if (bus.slave_entry_ready !== 1'b0) begin n_fail++; $display("FAIL rst_sready act=%b exp=%b", bus.slave_entry_ready, 1'b0); end
    n_checks++; if (bus.master_entry_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mvalid act=%b exp=%b", bus.master_entry_valid, 1'b0); end
    n_checks++; if (bus.master_entry !== 6'b000000) begin n_fail++; $display("FAIL rst_mentry act=%b exp=%b", bus.master_entry, 6'b000000); end
    n_checks++; if (bus.level !== 4'd0) begin n_fail++; $display("FAIL rst_level act=%0d exp=%0d", bus.level, 4'd0); end
    n_checks++; if ({bus.overflow, bus.underflow} !== 2'b00) begin n_fail++; $display("FAIL rst_flags act=%b exp=%b", {bus.overflow, bus.underflow}, 2'b00); end
    rst = 1'b0;
    #1;
    n_checks++; if (bus.slave_entry_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_sready act=%b exp=%b", bus.slave_entry_ready, 1'b1); end
    n_checks++; if (bus.master_entry_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_mvalid act=%b exp=%b", bus.master_entry_valid, 1'b0); end
  endtask

  task automatic test_single_beat();
    bus.slave_entry        = 9'b101100111;
    bus.slave_entry_valid  = 1'b1;
    bus.master_entry_ready = 1'b1;
    tick();
    bus.slave_entry_valid = 1'b0;
    n_checks++; if (bus.level !== 4'd3) begin n_fail++; $display("FAIL single_level3 act=%0d exp=%0d", bus.level, 4'd3); end
    n_checks++; if (bus.master_entry_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid act=%b exp=%b", bus.master_entry_valid, 1'b1); end
    n_checks++; if (bus.master_entry !== 6'b000111) begin n_fail++; $display("FAIL single_flush0 act=%b exp=%b", bus.master_entry, 6'b000111); end
    tick();
    n_checks++; if (bus.level !== 4'd2) begin n_fail++; $display("FAIL single_level2 act=%0d exp=%0d", bus.level, 4'd2); end
    n_checks++; if (bus.master_entry !== 6'b101100) begin n_fail++; $display("FAIL single_second act=%b exp=%b", bus.master_entry, 6'b101100); end
    tick();
    n_checks++; if (bus.level !== 4'd0) begin n_fail++; $display("FAIL single_level0 act=%0d exp=%0d", bus.level, 4'd0); end
    n_checks++; if ({bus.master_entry_valid, bus.master_entry} !== 7'b0000000) begin n_fail++; $display("FAIL single_empty act=%b exp=%b", {bus.master_entry_valid, bus.master_entry}, 7'b0000000); end
  endtask

  task automatic test_compaction();
    bus.slave_entry       = 9'b100000101;
    bus.slave_entry_valid = 1'b1;
    tick();
    bus.slave_entry_valid = 1'b0;
    n_checks++; if (bus.level !== 4'd2) begin n_fail++; $display("FAIL compact_level act=%0d exp=%0d", bus.level, 4'd2); end
    n_checks++; if ({bus.master_entry_valid, bus.master_entry} !== 7'b1100101) begin n_fail++; $display("FAIL compact_entry act=%b exp=%b", {bus.master_entry_valid, bus.master_entry}, 7'b1100101); end
    tick();
    n_checks++; if (bus.level !== 4'd0) begin n_fail++; $display("FAIL compact_drain act=%0d exp=%0d", bus.level, 4'd0); end
  endtask

  task automatic test_fill_overflow();
    bus.master_entry_ready = 1'b0;
    bus.slave_entry        = 9'b100100100;
    bus.slave_entry_valid  = 1'b1;
    tick();
    n_checks++; if (bus.level !== 4'd3) begin n_fail++; $display("FAIL fill_level3 act=%0d exp=%0d", bus.level, 4'd3); end
    tick();
    n_checks++; if (bus.level !== 4'd6) begin n_fail++; $display("FAIL fill_level6 act=%0d exp=%0d", bus.level, 4'd6); end
    n_checks++; if (bus.slave_entry_ready !== 1'b0) begin n_fail++; $display("FAIL fill_sready act=%b exp=%b", bus.slave_entry_ready, 1'b0); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL fill_ovf_early act=%b exp=%b", bus.overflow, 1'b0); end
    tick();
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL fill_ovf_set act=%b exp=%b", bus.overflow, 1'b1); end
    n_checks++; if (bus.level !== 4'd6) begin n_fail++; $display("FAIL fill_stall_level act=%0d exp=%0d", bus.level, 4'd6); end
    n_checks++; if (bus.master_entry !== 6'b100100) begin n_fail++; $display("FAIL fill_entry act=%b exp=%b", bus.master_entry, 6'b100100); end
    bus.master_entry_ready = 1'b1;
    tick();
    n_checks++; if (bus.level !== 4'd4) begin n_fail++; $display("FAIL drain_level4 act=%0d exp=%0d", bus.level, 4'd4); end
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL drain_ovf_held act=%b exp=%b", bus.overflow, 1'b1); end
    n_checks++; if (bus.slave_entry_ready !== 1'b1) begin n_fail++; $display("FAIL drain_sready act=%b exp=%b", bus.slave_entry_ready, 1'b1); end
    tick();
    bus.slave_entry_valid = 1'b0;
    n_checks++; if (bus.level !== 4'd5) begin n_fail++; $display("FAIL drain_level5 act=%0d exp=%0d", bus.level, 4'd5); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL drain_ovf_clr act=%b exp=%b", bus.overflow, 1'b0); end
    repeat (2) tick();
    bus.master_entry_ready = 1'b0;
    n_checks++; if (bus.level !== 4'd1) begin n_fail++; $display("FAIL drain_level1 act=%0d exp=%0d", bus.level, 4'd1); end
    n_checks++; if ({bus.master_entry_valid, bus.master_entry} !== 7'b0000000) begin n_fail++; $display("FAIL drain_partial_hold act=%b exp=%b", {bus.master_entry_valid, bus.master_entry}, 7'b0000000); end
    bus.slave_entry       = 9'b000000110;
    bus.slave_entry_valid = 1'b1;
    tick();
    bus.slave_entry_valid  = 1'b0;
    bus.master_entry_ready = 1'b1;
    n_checks++; if ({bus.master_entry_valid, bus.master_entry} !== 7'b1110100) begin n_fail++; $display("FAIL drain_last_entry act=%b exp=%b", {bus.master_entry_valid, bus.master_entry}, 7'b1110100); end
    tick();
    bus.master_entry_ready = 1'b0;
    n_checks++; if (bus.level !== 4'd0) begin n_fail++; $display("FAIL drain_empty act=%0d exp=%0d", bus.level, 4'd0); end
  endtask

  task automatic test_starve();
    bus.master_entry_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++; if (bus.underflow !== 1'b1) begin n_fail++; $display("FAIL starve_udf_%0d act=%b exp=%b", c, bus.underflow, 1'b1); end
      n_checks++; if (bus.master_entry !== 6'b000000) begin n_fail++; $display("FAIL starve_entry_%0d act=%b exp=%b", c, bus.master_entry, 6'b000000); end
    end
    bus.master_entry_ready = 1'b0;
    tick();
    n_checks++; if (bus.underflow !== 1'b0) begin n_fail++; $display("FAIL starve_udf_clr act=%b exp=%b", bus.underflow, 1'b0); end
  endtask

  task automatic test_async_reset_wrap();
    bus.slave_entry       = 9'b100101100;
    bus.slave_entry_valid = 1'b1;
    tick();
    bus.slave_entry = 9'b101100101;
    tick();
    bus.slave_entry_valid = 1'b0;
    n_checks++; if (bus.level !== 4'd6) begin n_fail++; $display("FAIL arst_pre_level act=%0d exp=%0d", bus.level, 4'd6); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.level !== 4'd0) begin n_fail++; $display("FAIL arst_level act=%0d exp=%0d", bus.level, 4'd0); end
    n_checks++; if ({bus.master_entry_valid, bus.master_entry} !== 7'b0000000) begin n_fail++; $display("FAIL arst_out act=%b exp=%b", {bus.master_entry_valid, bus.master_entry}, 7'b0000000); end
    #1 rst = 1'b0;
    #1;
    n_checks++; if (bus.slave_entry_ready !== 1'b1) begin n_fail++; $display("FAIL arst_sready act=%b exp=%b", bus.slave_entry_ready, 1'b1); end
    bus.slave_entry       = 9'b100101100;
    bus.slave_entry_valid = 1'b1;
    tick();
    bus.slave_entry = 9'b101100101;
    tick();
    n_checks++; if (bus.level !== 4'd6) begin n_fail++; $display("FAIL wrap_level6 act=%0d exp=%0d", bus.level, 4'd6); end
    bus.slave_entry        = 9'b111100101;
    bus.master_entry_ready = 1'b1;
    n_checks++; if ({bus.slave_entry_ready, bus.master_entry} !== 7'b0101100) begin n_fail++; $display("FAIL wrap_pop0 act=%b exp=%b", {bus.slave_entry_ready, bus.master_entry}, 7'b0101100); end
    tick();
    n_checks++; if (bus.level !== 4'd4) begin n_fail++; $display("FAIL wrap_level4 act=%0d exp=%0d", bus.level, 4'd4); end
    n_checks++; if (bus.master_entry !== 6'b101100) begin n_fail++; $display("FAIL wrap_pop1 act=%b exp=%b", bus.master_entry, 6'b101100); end
    tick();
    bus.slave_entry_valid = 1'b0;
    n_checks++; if (bus.level !== 4'd5) begin n_fail++; $display("FAIL wrap_level5 act=%0d exp=%0d", bus.level, 4'd5); end
    n_checks++; if (bus.master_entry !== 6'b101100) begin n_fail++; $display("FAIL wrap_pop2 act=%b exp=%b", bus.master_entry, 6'b101100); end
    tick();
    n_checks++; if ({bus.level, bus.master_entry} !== 10'b0011_100101) begin n_fail++; $display("FAIL wrap_slot_wrap act=%b exp=%b", {bus.level, bus.master_entry}, 10'b0011_100101); end
    tick();
    n_checks++; if ({bus.level, bus.master_entry_valid, bus.master_entry} !== 11'b0001_1_000111) begin n_fail++; $display("FAIL wrap_flush act=%b exp=%b", {bus.level, bus.master_entry_valid, bus.master_entry}, 11'b0001_1_000111); end
    tick();
    bus.master_entry_ready = 1'b0;
    n_checks++; if ({bus.level, bus.master_entry_valid} !== 5'b0000_0) begin n_fail++; $display("FAIL wrap_empty act=%b exp=%b", {bus.level, bus.master_entry_valid}, 5'b0000_0); end
  endtask

  initial begin
    clk      = 1'b0;
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_beat();
    test_compaction();
    test_fill_overflow();
    test_starve();
    test_async_reset_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
